// File: rtl/demux1to8_seq_pkg.sv
// Shared constants for the registered 1-to-8 demultiplexer.
// Lane count, select width and the lane-slice helper.
`ifndef DEMUX1TO8_SEQ_PKG_SV
`define DEMUX1TO8_SEQ_PKG_SV

// Low bit of lane i in a packed bus of WIDTH-bit lanes
`define DEMUX_LO(i, w) ((i) * (w))

package demux1to8_seq_pkg;
    localparam int LANES = 8;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] LAST_LANE = 3'd7;
endpackage

`endif

// File: rtl/demux1to8_seq_lane.sv
// One output lane: data register plus valid flag.
// Reports when a write would clobber unconsumed data.
module demux_lane_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] d_reset,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             ovr
);
    logic [WIDTH-1:0] q_q;
    logic             valid_q;

    // A write carrying its own ack is a hand-off, not a loss
    always_comb begin
        ovr = wr & valid_q & ~ack;
    end

    // Write wins over ack; ack only clears the flag, data is kept
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q     <= d_reset;
            valid_q <= 1'b0;
        end else if (wr) begin
            q_q     <= d;
            valid_q <= 1'b1;
        end else if (ack) begin
            valid_q <= 1'b0;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
endmodule

// File: rtl/demux1to8_seq.sv
// Registered 1-to-8 demultiplexer with per-lane valid/ack.
// Target is an external select or a round-robin pointer.
module demux1to8_seq
    import demux1to8_seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   in_valid,
    input  logic [SEL_W-1:0]       select,
    input  logic                   auto,
    input  logic [LANES-1:0]       out_ack,
    output logic [LANES*WIDTH-1:0] out,
    output logic [LANES-1:0]       out_valid,
    output logic [SEL_W-1:0]       pointer,
    output logic                   overwrite,
    output logic                   frame_done
);
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] target;
    logic [LANES-1:0] wr_vec;
    logic [LANES-1:0] ovr_vec;
    logic             ovr_q, ovr_d;
    logic             frame_q, frame_d;

    // Target decode, pointer advance and pulse conditions
    always_comb begin
        target  = auto ? ptr_q : select;
        wr_vec  = '0;
        ptr_d   = ptr_q;
        ovr_d   = 1'b0;
        frame_d = 1'b0;
        if (in_valid) begin
            wr_vec = LANES'(1) << target;
            ovr_d  = |ovr_vec;
            if (auto) begin
                ptr_d   = ptr_q + 3'd1;
                frame_d = (ptr_q == LAST_LANE);
            end
        end
    end

    // Pointer and one-cycle status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            ovr_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            ovr_q   <= ovr_d;
            frame_q <= frame_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .wr      (wr_vec[i]),
            .ack     (out_ack[i]),
            .d       (in),
            .d_reset (in_reset),
            .q       (out[`DEMUX_LO(i, WIDTH) +: WIDTH]),
            .valid   (out_valid[i]),
            .ovr     (ovr_vec[i])
        );
    end

    assign pointer    = ptr_q;
    assign overwrite  = ovr_q;
    assign frame_done = frame_q;
endmodule

// File: tb/tb_demux1to8_seq.sv
// Directed bench for demux1to8_seq, WIDTH = 8.
// Each task drives one scenario and checks inline.
module tb_demux1to8_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_reset;
    logic [7:0]  in;
    logic        in_valid;
    logic [2:0]  select;
    logic        auto;
    logic [7:0]  out_ack;
    logic [63:0] out;
    logic [7:0]  out_valid;
    logic [2:0]  pointer;
    logic        overwrite;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    demux1to8_seq #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_reset   (in_reset),
        .in         (in),
        .in_valid   (in_valid),
        .select     (select),
        .auto       (auto),
        .out_ack    (out_ack),
        .out        (out),
        .out_valid  (out_valid),
        .pointer    (pointer),
        .overwrite  (overwrite),
        .frame_done (frame_done)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ack  = '0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_reset = 8'hA5;
        in       = 8'hFF;
        select   = 3'd0;
        auto     = 1'b0;
        // concurrent write and ack must be overridden by reset
        reset    = 1'b1;
        in_valid = 1'b1;
        out_ack  = 8'hFF;
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ack  = '0;
        checks++;
        if (out !== {8{8'hA5}}) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", out, {8{8'hA5}});
        end
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL reset_valid got=%h exp=00", out_valid);
        end
        checks++;
        if (pointer !== 3'd0) begin
            errors++;
            $display("FAIL reset_ptr got=%0d exp=0", pointer);
        end
        checks++;
        if ({overwrite, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=00",
                     {overwrite, frame_done});
        end
    endtask

    task automatic test_select();
        do_reset();
        auto     = 1'b0;
        in_valid = 1'b1;
        select   = 3'd3;
        in       = 8'h11;
        cyc();
        select   = 3'd5;
        in       = 8'h22;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out !== 64'hA5A5_22A5_11A5_A5A5) begin
            errors++;
            $display("FAIL sel_out got=%h exp=%h",
                     out, 64'hA5A5_22A5_11A5_A5A5);
        end
        checks++;
        if (out_valid !== 8'b0010_1000) begin
            errors++;
            $display("FAIL sel_valid got=%b exp=00101000", out_valid);
        end
        checks++;
        if (pointer !== 3'd0) begin
            errors++;
            $display("FAIL sel_ptr got=%0d exp=0", pointer);
        end
        checks++;
        if (overwrite !== 1'b0) begin
            errors++;
            $display("FAIL sel_ovr got=%b exp=0", overwrite);
        end
    endtask

    task automatic test_back_to_back();
        int fd_early = 0;
        do_reset();
        auto     = 1'b1;
        in_valid = 1'b1;
        select   = 3'd7;
        for (int i = 0; i < 8; i++) begin
            in = 8'(i);
            cyc();
            if (i < 7 && frame_done) fd_early++;
        end
        in_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL auto_frame got=%b exp=1", frame_done);
        end
        checks++;
        if (fd_early != 0) begin
            errors++;
            $display("FAIL auto_frame_early got=%0d exp=0", fd_early);
        end
        checks++;
        if (out !== 64'h0706_0504_0302_0100) begin
            errors++;
            $display("FAIL auto_out got=%h exp=%h",
                     out, 64'h0706_0504_0302_0100);
        end
        checks++;
        if (out_valid !== 8'hFF) begin
            errors++;
            $display("FAIL auto_valid got=%h exp=FF", out_valid);
        end
        checks++;
        if (pointer !== 3'd0) begin
            errors++;
            $display("FAIL auto_wrap got=%0d exp=0", pointer);
        end
        cyc();
        checks++;
        if ({frame_done, overwrite} !== 2'b00) begin
            errors++;
            $display("FAIL auto_idle got=%b exp=00",
                     {frame_done, overwrite});
        end
        // lane 7 via select must not signal a frame
        auto     = 1'b0;
        in_valid = 1'b1;
        out_ack  = 8'h80;
        in       = 8'h77;
        cyc();
        in_valid = 1'b0;
        out_ack  = '0;
        checks++;
        if ({frame_done, pointer} !== 4'b0000) begin
            errors++;
            $display("FAIL sel7_frame got=%b exp=0000",
                     {frame_done, pointer});
        end
    endtask

    task automatic test_overwrite();
        do_reset();
        auto     = 1'b0;
        select   = 3'd2;
        in_valid = 1'b1;
        in       = 8'h33;
        cyc();
        in       = 8'h44;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (overwrite !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse got=%b exp=1", overwrite);
        end
        cyc();
        checks++;
        if (overwrite !== 1'b0) begin
            errors++;
            $display("FAIL ovr_once got=%b exp=0", overwrite);
        end
        checks++;
        if (out[23:16] !== 8'h44) begin
            errors++;
            $display("FAIL ovr_data got=%h exp=44", out[23:16]);
        end
        in_valid = 1'b1;
        in       = 8'h55;
        out_ack  = 8'h04;
        cyc();
        in_valid = 1'b0;
        out_ack  = '0;
        checks++;
        if ({overwrite, out_valid[2]} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_ack got=%b exp=01",
                     {overwrite, out_valid[2]});
        end
        checks++;
        if (out[23:16] !== 8'h55) begin
            errors++;
            $display("FAIL ovr_ack_data got=%h exp=55", out[23:16]);
        end
    endtask

    task automatic test_ack();
        do_reset();
        auto     = 1'b0;
        in_valid = 1'b1;
        select   = 3'd4;
        in       = 8'h66;
        cyc();
        // write lane 1 while acking lane 4
        select   = 3'd1;
        in       = 8'h99;
        out_ack  = 8'h10;
        cyc();
        in_valid = 1'b0;
        out_ack  = '0;
        checks++;
        if (out_valid !== 8'h02) begin
            errors++;
            $display("FAIL ack_valid got=%h exp=02", out_valid);
        end
        checks++;
        if (out[39:32] !== 8'h66 || out[15:8] !== 8'h99) begin
            errors++;
            $display("FAIL ack_data got=%h/%h exp=66/99",
                     out[39:32], out[15:8]);
        end
        out_ack = 8'h40;
        cyc();
        out_ack = '0;
        checks++;
        if (out_valid !== 8'h02 || overwrite !== 1'b0) begin
            errors++;
            $display("FAIL ack_invalid got=%h/%b exp=02/0",
                     out_valid, overwrite);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in = 8'h10 + 8'(i);
            cyc();
        end
        checks++;
        if (pointer !== 3'd4) begin
            errors++;
            $display("FAIL mid_ptr got=%0d exp=4", pointer);
        end
        in    = 8'h14;
        reset = 1'b1;
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out !== {8{8'hA5}} || out_valid !== 8'h00) begin
            errors++;
            $display("FAIL mid_lanes got=%h/%h exp=%h/00",
                     out, out_valid, {8{8'hA5}});
        end
        checks++;
        if ({pointer, overwrite, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL mid_state got=%b exp=00000",
                     {pointer, overwrite, frame_done});
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_reset = 8'hA5;
        in       = '0;
        in_valid = 1'b0;
        select   = '0;
        auto     = 1'b0;
        out_ack  = '0;
        test_reset();
        test_select();
        test_back_to_back();
        test_overwrite();
        test_ack();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux1to8_seq.md
# demux1to8_seq

Registered 1-to-8 demultiplexer with per-lane valid/acknowledge handshake: the distribution-side counterpart of the registered 8-to-1 selector. A single WIDTH-bit word is steered into one of eight output lane registers, chosen either by an external select or by an internal round-robin pointer. It sits between a single producer and up to eight independent consumers. It reports lane overwrites and completed 8-lane frames.

## Interface
Parameters:
- WIDTH, default 1, bit width of one lane.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_reset  input  WIDTH  value loaded into every lane register on reset.
- in  input  WIDTH  data word to distribute.
- in_valid  input  1  write strobe; `in` is captured this cycle.
- select  input  3  target lane when auto = 0.
- auto  input  1  1: target is the internal pointer; 0: target is select.
- out_ack  input  8  per-lane consumer acknowledge; bit i clears out_valid[i].
- out  output  8*WIDTH  lane i at out[(i+1)*WIDTH-1 : i*WIDTH].
- out_valid  output  8  lane i holds unconsumed data.
- pointer  output  3  current round-robin pointer.
- overwrite  output  1  one-cycle pulse: an unconsumed lane was overwritten.
- frame_done  output  1  one-cycle pulse: auto-mode write to lane 7 occurred.

## Operation
- Target lane t = auto ? pointer : select, evaluated in the cycle in_valid is high.
- in_valid = 1: lane t register <= in; out_valid[t] <= 1. All other lane registers hold.
- Overwrite: if out_valid[t] = 1 and out_ack[t] = 0 in the write cycle, overwrite = 1 next cycle. The write still takes effect; the new data replaces the old.
- Acknowledge: out_ack[i] = 1 with no write to lane i clears out_valid[i] next cycle. Lane data is retained. Ack on a lane with valid = 0 has no effect.
- Simultaneous write and ack on the same lane: the write wins. Valid stays 1 and no overwrite pulse is generated.
- Acks on other lanes in a write cycle are processed independently.
- Pointer advances by 1 mod 8 (7 wraps to 0) only on in_valid with auto = 1. It holds when auto = 0 or in_valid = 0. Switching auto mid-frame does not reset the pointer.
- frame_done = 1 in the cycle after an auto-mode write with pointer = 7. Writes to lane 7 via select do not trigger it.
- in_valid = 0: no lane, valid, or pointer change except ack clears. overwrite and frame_done are 0.

## Timing
- Reset (synchronous, sampled at rising edge): every lane <= in_reset, out_valid = 8'h00, pointer = 0, overwrite = 0, frame_done = 0. Reset overrides any concurrent in_valid or out_ack.
- Reset mid-frame discards all lane data and the pointer position.
- Write latency: 1 cycle. Data sampled at edge N is visible on out and out_valid after edge N.
- Ack latency: 1 cycle.
- overwrite and frame_done are registered and asserted for exactly one cycle per triggering write.
- Back-to-back in_valid every cycle is supported at full throughput, with no stall.
- There is no backpressure: the producer is never blocked, and loss of data is signalled only via overwrite.

## Structure
- Shared package/include: LANES = 8, SEL_W = 3, and a lane-slice index helper macro (lo = i*WIDTH).
- One sub-module, demux_lane_reg (WIDTH parameter). It holds one lane's data register and valid flag, with inputs wr, ack, d, d_reset and outputs q, valid, and an overwrite-condition output.
- Top level instantiates 8 lanes via generate, plus the pointer counter, target decode, and registered overwrite/frame_done.

## Test plan
- Reset with in_reset = 8'hA5 (WIDTH = 8) -> all 8 lanes read A5, out_valid = 00, pointer = 0, pulses = 0.
- auto = 0, writes 8'h11 to select 3 then 8'h22 to select 5 -> lane3 = 11, lane5 = 22, out_valid = 8'b0010_1000, pointer stays 0.
- auto = 1, eight consecutive writes 8'h00..8'h07 -> lane i = i, out_valid = FF. frame_done pulses once, one cycle after the eighth write. pointer wraps to 0.
- Write lane 2 twice without ack -> overwrite pulses once, lane2 holds the second value. Repeat with out_ack[2] = 1 in the second write cycle -> no overwrite, valid stays 1.
- Ack-only on lane 4 (valid = 1) -> out_valid[4] = 0 next cycle and lane4 data unchanged. Ack on an invalid lane -> no change.
- Assert reset on the cycle of the 5th auto-mode write -> the write is discarded, all lanes = in_reset, pointer = 0, no pulses.
